// File: rtl/hline_sched_pkg.sv
// hline_sched_pkg: shared states and timing constants for the hline scheduler
package hline_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HIT, OVER} state_t;
  localparam int NUM_LINES      = 3;
  localparam int STAGGER_FRAMES = 32;
  localparam int FLASH_HALF     = 8;
  localparam int FLASH_TOGGLES  = 8;
  localparam int LIVES_INIT     = 3;
  localparam int FRAME_MAX      = (NUM_LINES - 1) * STAGGER_FRAMES;
endpackage

// File: rtl/hline_scheduler_if.sv
// hline_scheduler_if: game inputs and per-line control outputs of the scheduler
interface hline_scheduler_if;
  import hline_sched_pkg::*;
  logic frame, btn_go, hit, pass;
  logic [NUM_LINES-1:0] start_machine, load_counter, stop;
  logic flash, game_over;
  logic [1:0] lives;
  logic [7:0] score;
  modport master (output frame, btn_go, hit, pass,
                  input start_machine, load_counter, stop, flash, lives, score, game_over);
  modport slave (input frame, btn_go, hit, pass,
                 output start_machine, load_counter, stop, flash, lives, score, game_over);
endinterface

// File: rtl/rise_detect.sv
// rise_detect: one-bit rising-edge detector against a registered history bit
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic prev_q;
  always_ff @(posedge clk)
    if (!reset_n) prev_q <= 1'b0;
    else prev_q <= d;
  assign rise = d & ~prev_q;
endmodule

// File: rtl/hline_scheduler.sv
// hline_scheduler: game FSM sequencing line load, staggered start, hit flash and lives/score
module hline_scheduler import hline_sched_pkg::*; (
  input logic clk,
  input logic reset,
  hline_scheduler_if.slave bus
);
  logic frame_rise, go_rise, pass_rise, toggle, hit_run;
  state_t state_q, state_d;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic [2:0] flash_cnt_q, flash_cnt_d, toggle_cnt_q, toggle_cnt_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [NUM_LINES-1:0] start_q, start_d, stop_q, stop_d, load_q, load_d, stag;
  logic flash_q, flash_d, over_q, over_d;

  rise_detect u_frame (.clk(clk), .reset_n(reset), .d(bus.frame),  .rise(frame_rise));
  rise_detect u_go    (.clk(clk), .reset_n(reset), .d(bus.btn_go), .rise(go_rise));
  rise_detect u_pass  (.clk(clk), .reset_n(reset), .d(bus.pass),   .rise(pass_rise));

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    flash_cnt_d  = flash_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    lives_d      = lives_q;
    score_d      = score_q;
    for (int k = 0; k < NUM_LINES; k++) stag[k] = int'(frame_cnt_q) >= k * STAGGER_FRAMES;
    toggle  = state_q == HIT && frame_rise && flash_cnt_q == 3'(FLASH_HALF - 1);
    hit_run = state_q == RUN && bus.hit;
    if ((state_q == IDLE || state_q == OVER) && go_rise) begin
      state_d     = LOAD;
      lives_d     = 2'(LIVES_INIT);
      score_d     = '0;
      frame_cnt_d = '0;
    end else if (state_q == LOAD && frame_rise) begin
      state_d     = frame_cnt_q == 7'd1 ? RUN : LOAD;
      frame_cnt_d = frame_cnt_q == 7'd1 ? 7'd0 : frame_cnt_q + 7'd1;
    end else if (hit_run) begin
      state_d      = HIT;
      lives_d      = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
      flash_cnt_d  = '0;
      toggle_cnt_d = '0;
    end else if (state_q == RUN) begin
      frame_cnt_d = frame_rise && frame_cnt_q != 7'(FRAME_MAX) ? frame_cnt_q + 7'd1 : frame_cnt_q;
      score_d     = pass_rise && score_q != 8'hff ? score_q + 8'd1 : score_q;
    end else if (state_q == HIT && frame_rise) begin
      flash_cnt_d  = toggle ? 3'd0 : flash_cnt_q + 3'd1;
      toggle_cnt_d = toggle ? toggle_cnt_q + 3'd1 : toggle_cnt_q;
      if (toggle && toggle_cnt_q == 3'(FLASH_TOGGLES - 1)) begin
        state_d     = lives_q == 2'd0 ? OVER : LOAD;
        frame_cnt_d = '0;
      end
    end
    // Stagger is only accumulated while staying in RUN so entry always starts from 000
    load_d  = state_d == IDLE || state_d == LOAD ? '1 : '0;
    stop_d  = state_d == RUN && state_q == RUN ? stop_q | stag : '0;
    start_d = state_d == HIT ? start_q : stop_d;
    flash_d = state_d == HIT ? flash_q ^ toggle : 1'b1;
    over_d  = state_d == OVER;
  end

  always_ff @(posedge clk)
    if (!reset) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      flash_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      lives_q      <= 2'(LIVES_INIT);
      score_q      <= '0;
      start_q      <= '0;
      stop_q       <= '0;
      load_q       <= '1;
      flash_q      <= 1'b1;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      load_q       <= load_d;
      flash_q      <= flash_d;
      over_q       <= over_d;
    end

  assign bus.start_machine = start_q;
  assign bus.stop          = stop_q;
  assign bus.load_counter  = load_q;
  assign bus.flash         = flash_q;
  assign bus.lives         = lives_q;
  assign bus.score         = score_q;
  assign bus.game_over     = over_q;
endmodule

// File: tb/tb_hline_scheduler.sv
// tb_hline_scheduler: directed checks of load, stagger, scoring, hit flash, game over and reset
module tb_hline_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  hline_scheduler_if bus();
  hline_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame = 1'b1; step();
      bus.frame = 1'b0; step();
    end
  endtask

  task automatic pass_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pass = 1'b1; step();
      bus.pass = 1'b0; step();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " load"}, 32'(bus.load_counter), 32'd7);
    chk({tag, " stop"}, 32'(bus.stop), 32'd0);
    chk({tag, " start"}, 32'(bus.start_machine), 32'd0);
    chk({tag, " flash"}, 32'(bus.flash), 32'd1);
    chk({tag, " lives"}, 32'(bus.lives), 32'd3);
    chk({tag, " score"}, 32'(bus.score), 32'd0);
    chk({tag, " over"}, 32'(bus.game_over), 32'd0);
  endtask

  initial begin
    bus.frame = 1'b0; bus.btn_go = 1'b0; bus.hit = 1'b0; bus.pass = 1'b0;
    step(); step();
    chk_reset_state("reset");
    reset = 1'b1;
    step();
    bus.btn_go = 1'b1; step();
    chk("load after go", 32'(bus.load_counter), 32'd7);
    bus.btn_go = 1'b0; step();
    frame_pulse(1);
    chk("load after 1 frame", 32'(bus.load_counter), 32'd7);
    bus.frame = 1'b1; step();
    chk("run entry load", 32'(bus.load_counter), 32'd0);
    chk("run entry stop", 32'(bus.stop), 32'd0);
    bus.frame = 1'b0; step();
    chk("run stop line0", 32'(bus.stop), 32'd1);
    chk("run start line0", 32'(bus.start_machine), 32'd1);
    pass_pulse(5);
    chk("score 5", 32'(bus.score), 32'd5);
    frame_pulse(31);
    chk("stop at frame 31", 32'(bus.stop), 32'd1);
    frame_pulse(1);
    chk("stop at frame 32", 32'(bus.stop), 32'd3);
    frame_pulse(31);
    chk("stop at frame 63", 32'(bus.stop), 32'd3);
    frame_pulse(1);
    chk("stop at frame 64", 32'(bus.stop), 32'd7);
    chk("start at frame 64", 32'(bus.start_machine), 32'd7);
    bus.hit = 1'b1; bus.pass = 1'b1; step();
    chk("hit lives", 32'(bus.lives), 32'd2);
    chk("hit stop", 32'(bus.stop), 32'd0);
    chk("hit start held", 32'(bus.start_machine), 32'd7);
    chk("hit pass ignored", 32'(bus.score), 32'd5);
    bus.hit = 1'b0; bus.pass = 1'b0; step();
    frame_pulse(7);
    chk("flash before 8 frames", 32'(bus.flash), 32'd1);
    bus.frame = 1'b1; step();
    chk("flash low at 8 frames", 32'(bus.flash), 32'd0);
    bus.frame = 1'b0; step();
    bus.hit = 1'b1; step(); bus.hit = 1'b0; step();
    chk("hit in HIT ignored", 32'(bus.lives), 32'd2);
    bus.btn_go = 1'b1; step(); bus.btn_go = 1'b0; step();
    chk("go in HIT ignored", 32'(bus.load_counter), 32'd0);
    frame_pulse(55);
    chk("flash after 63 frames", 32'(bus.flash), 32'd0);
    bus.frame = 1'b1; step();
    chk("HIT end flash", 32'(bus.flash), 32'd1);
    chk("HIT end load", 32'(bus.load_counter), 32'd7);
    chk("HIT end start", 32'(bus.start_machine), 32'd0);
    bus.frame = 1'b0; step();
    frame_pulse(2);
    bus.hit = 1'b1; step(); bus.hit = 1'b0; step();
    chk("second hit lives", 32'(bus.lives), 32'd1);
    frame_pulse(64);
    bus.hit = 1'b1; step(); bus.hit = 1'b0; step();
    chk("hit in LOAD ignored", 32'(bus.lives), 32'd1);
    frame_pulse(2);
    bus.hit = 1'b1; step(); bus.hit = 1'b0; step();
    chk("third hit lives", 32'(bus.lives), 32'd0);
    frame_pulse(64);
    chk("over game_over", 32'(bus.game_over), 32'd1);
    chk("over load", 32'(bus.load_counter), 32'd0);
    chk("over flash", 32'(bus.flash), 32'd1);
    chk("over score held", 32'(bus.score), 32'd5);
    bus.hit = 1'b1; step(); bus.hit = 1'b0; step();
    chk("hit in OVER lives", 32'(bus.lives), 32'd0);
    bus.btn_go = 1'b1; step();
    chk("restart lives", 32'(bus.lives), 32'd3);
    chk("restart score", 32'(bus.score), 32'd0);
    chk("restart over", 32'(bus.game_over), 32'd0);
    chk("restart load", 32'(bus.load_counter), 32'd7);
    bus.btn_go = 1'b0; step();
    frame_pulse(2);
    pass_pulse(255);
    chk("score 255", 32'(bus.score), 32'd255);
    pass_pulse(1);
    chk("score saturates", 32'(bus.score), 32'd255);
    bus.hit = 1'b1; step(); bus.hit = 1'b0; step();
    frame_pulse(8);
    chk("mid-HIT flash", 32'(bus.flash), 32'd0);
    reset = 1'b0; step();
    chk_reset_state("mid-HIT reset");
    reset = 1'b1; step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
